// File: rtl/mont_pre.sv
`default_nettype none
// ============================================================================
// Module   : mont_pre
// Brief    : Montgomery-domain pre-processing: M_bar = M*R mod n,
//            x_bar = R mod n, e_idx = MSB index of e, with R = 2^BITLEN.
// Revision : 1.0 - initial release
// ============================================================================
module mont_pre #(
    parameter int BITLEN     = 1024,
    parameter int LOG_BITLEN = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITLEN-1:0]     M,
    input  logic [BITLEN-1:0]     e,
    input  logic [BITLEN-1:0]     n,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BITLEN-1:0]     M_bar,
    output logic [BITLEN-1:0]     x_bar,
    output logic [LOG_BITLEN-1:0] e_idx
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        LOOP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [BITLEN-1:0]     m_lat, e_lat, n_lat;
    logic [BITLEN-1:0]     rm, rx, rm_nx, rx_nx;
    logic [LOG_BITLEN-1:0] cnt;
    logic                  op_bad;
    logic                  last_iter;

    // Modular doubling; the doubled value needs one extra bit before the
    // single conditional subtract brings it back below n.
    function automatic logic [BITLEN-1:0] mod_dbl(
        input logic [BITLEN-1:0] r,
        input logic [BITLEN-1:0] modulus
    );
        logic [BITLEN:0] t;
        logic [BITLEN:0] nx;
        logic [BITLEN:0] red;
        t   = {r, 1'b0};
        nx  = {1'b0, modulus};
        red = (t >= nx) ? (t - nx) : t;
        return red[BITLEN-1:0];
    endfunction

    assign rm_nx     = mod_dbl(rm, n_lat);
    assign rx_nx     = mod_dbl(rx, n_lat);
    assign last_iter = (cnt == LOG_BITLEN'(BITLEN - 1));
    assign op_bad    = (n_lat <= BITLEN'(1)) || (m_lat >= n_lat) || (e_lat == '0);

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = op_bad ? DONE : LOOP;
            LOOP:    if (last_iter) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_lat <= '0;
            e_lat <= '0;
            n_lat <= '0;
            rm    <= '0;
            rx    <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            M_bar <= '0;
            x_bar <= '0;
            e_idx <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    m_lat <= M;
                    e_lat <= e;
                    n_lat <= n;
                    rm    <= M;
                    rx    <= BITLEN'(1);
                    cnt   <= '0;
                    e_idx <= '0;
                    err   <= 1'b0;
                end
                LOAD: if (op_bad) begin
                    err   <= 1'b1;
                    M_bar <= '0;
                    x_bar <= '0;
                    e_idx <= '0;
                end
                LOOP: begin
                    rm  <= rm_nx;
                    rx  <= rx_nx;
                    cnt <= cnt + LOG_BITLEN'(1);
                    // Ascending scan: the last set bit seen is the MSB.
                    if (e_lat[cnt]) e_idx <= cnt;
                    if (last_iter) begin
                        M_bar <= rm_nx;
                        x_bar <= rx_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mont_pre.sv
`default_nettype none
// ============================================================================
// Module   : tb_mont_pre
// Brief    : Self-checking bench for mont_pre at BITLEN=8 and BITLEN=16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mont_pre;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic       start8 = 1'b0;
    logic [7:0] m8 = '0, e8 = '0, n8 = '0;
    logic       busy8, done8, err8;
    logic [7:0] mbar8, xbar8;
    logic [2:0] eidx8;

    logic        start16 = 1'b0;
    logic [15:0] m16 = '0, e16 = '0, n16 = '0;
    logic        busy16, done16, err16;
    logic [15:0] mbar16, xbar16;
    logic [3:0]  eidx16;

    mont_pre #(.BITLEN(8), .LOG_BITLEN(3)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .M(m8), .e(e8), .n(n8),
        .busy(busy8), .done(done8), .err(err8),
        .M_bar(mbar8), .x_bar(xbar8), .e_idx(eidx8)
    );

    mont_pre #(.BITLEN(16), .LOG_BITLEN(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .M(m16), .e(e16), .n(n16),
        .busy(busy16), .done(done16), .err(err16),
        .M_bar(mbar16), .x_bar(xbar16), .e_idx(eidx16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic on 64-bit integers.
    function automatic void model(input longint m, input longint ee, input longint nn,
                                  input int w, output bit x_err, output longint x_mb,
                                  output longint x_xb, output int x_idx, output int x_lat);
        x_err = (nn <= 1) || (m >= nn) || (ee == 0);
        x_mb = 0; x_xb = 0; x_idx = 0;
        if (x_err) begin
            x_lat = 1;
        end else begin
            x_mb  = (m * (longint'(1) << w)) % nn;
            x_xb  = (longint'(1) << w) % nn;
            for (int b = 0; b < w; b++) if ((ee >> b) & 1) x_idx = b;
            x_lat = w + 1;
        end
    endfunction

    task automatic run8(input logic [7:0] m, input logic [7:0] ee, input logic [7:0] nn,
                        output int lat);
        m8 = m; e8 = ee; n8 = nn; start8 = 1'b1;
        step();
        start8 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (done8) begin lat = k; break; end
        end
    endtask

    task automatic run16(input logic [15:0] m, input logic [15:0] ee, input logic [15:0] nn,
                         output int lat);
        m16 = m; e16 = ee; n16 = nn; start16 = 1'b1;
        step();
        start16 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (done16) begin lat = k; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy8, done8, err8, mbar8, xbar8, eidx8} !== '0) begin
            failures++;
            $display("FAIL reset8: busy=%b done=%b err=%b mbar=%0d xbar=%0d eidx=%0d required all 0",
                     busy8, done8, err8, mbar8, xbar8, eidx8);
        end
        checks++;
        if ({busy16, done16, err16, mbar16, xbar16, eidx16} !== '0) begin
            failures++;
            $display("FAIL reset16: busy=%b done=%b err=%b required all 0", busy16, done16, err16);
        end
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    // Directed operand table: nominal, edge operands and the three error cases.
    task automatic test_directed();
        logic [7:0] tm [6] = '{8'd5,  8'd254, 8'd0, 8'd13, 8'd0, 8'd5};
        logic [7:0] te [6] = '{8'h0B, 8'h80,  8'h01, 8'h01, 8'h01, 8'h00};
        logic [7:0] tn [6] = '{8'd13, 8'd255, 8'd3, 8'd13, 8'd1, 8'd13};
        int lat, x_lat, x_idx;
        bit x_err;
        longint x_mb, x_xb;
        for (int i = 0; i < 6; i++) begin
            model(tm[i], te[i], tn[i], 8, x_err, x_mb, x_xb, x_idx, x_lat);
            run8(tm[i], te[i], tn[i], lat);
            checks++;
            if (lat != x_lat || err8 !== x_err || longint'(mbar8) != x_mb ||
                longint'(xbar8) != x_xb || int'(eidx8) != x_idx) begin
                failures++;
                $display("FAIL directed[%0d]: lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d required lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d",
                         i, lat, err8, mbar8, xbar8, eidx8, x_lat, x_err, x_mb, x_xb, x_idx);
            end
            step();
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0 || longint'(mbar8) != x_mb || err8 !== x_err) begin
                failures++;
                $display("FAIL directed_hold[%0d]: done=%b busy=%b mbar=%0d err=%b required done=0 busy=0 mbar=%0d err=%b",
                         i, done8, busy8, mbar8, err8, x_mb, x_err);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0, first = -1;
        logic [7:0] mb_at = '0, xb_at = '0;
        m8 = 8'd5; n8 = 8'd13; e8 = 8'd11; start8 = 1'b1;
        step();
        for (int k = 1; k <= 19; k++) begin
            step();
            if (done8) begin
                pulses++;
                if (first < 0) begin first = k; mb_at = mbar8; xb_at = xbar8; end
            end
        end
        start8 = 1'b0;
        checks++;
        if (pulses != 1 || first != 9 || mb_at !== 8'd6 || xb_at !== 8'd9) begin
            failures++;
            $display("FAIL busy_ignore: pulses=%0d first=%0d mbar=%0d xbar=%0d required pulses=1 first=9 mbar=6 xbar=9",
                     pulses, first, mb_at, xb_at);
        end
        step();
        checks++;
        if (done8 !== 1'b1 || eidx8 !== 3'd3 || err8 !== 1'b0) begin
            failures++;
            $display("FAIL busy_second: done=%b eidx=%0d err=%b required done=1 eidx=3 err=0",
                     done8, eidx8, err8);
        end
        step();
    endtask

    task automatic test_reset_mid_loop();
        int lat, x_lat, x_idx, seen;
        bit x_err;
        longint x_mb, x_xb;
        m8 = 8'd9; n8 = 8'd250; e8 = 8'h40; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if (busy8 !== 1'b1) begin
            failures++;
            $display("FAIL midloop_busy: busy=%b required 1", busy8);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, err8, mbar8, xbar8, eidx8} !== '0) begin
            failures++;
            $display("FAIL midloop_reset: busy=%b done=%b err=%b mbar=%0d xbar=%0d eidx=%0d required all 0",
                     busy8, done8, err8, mbar8, xbar8, eidx8);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (done8 || busy8) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL midloop_nodone: active_cycles=%0d required 0", seen);
        end
        model(8'd7, 8'h2C, 8'd11, 8, x_err, x_mb, x_xb, x_idx, x_lat);
        run8(8'd7, 8'h2C, 8'd11, lat);
        checks++;
        if (lat != x_lat || err8 !== x_err || longint'(mbar8) != x_mb ||
            longint'(xbar8) != x_xb || int'(eidx8) != x_idx) begin
            failures++;
            $display("FAIL midloop_restart: lat=%0d mbar=%0d xbar=%0d eidx=%0d required lat=%0d mbar=%0d xbar=%0d eidx=%0d",
                     lat, mbar8, xbar8, eidx8, x_lat, x_mb, x_xb, x_idx);
        end
        step();
    endtask

    task automatic test_random8();
        int lat, x_lat, x_idx;
        bit x_err;
        longint x_mb, x_xb;
        logic [7:0] m, ee, nn;
        for (int i = 0; i < 40; i++) begin
            nn = 8'($urandom_range(0, 255));
            m  = 8'($urandom_range(0, 255));
            ee = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) != 0 && nn > 1) m = m % nn;
            if ($urandom_range(0, 9) != 0 && ee == 0) ee = 8'h01;
            model(m, ee, nn, 8, x_err, x_mb, x_xb, x_idx, x_lat);
            run8(m, ee, nn, lat);
            checks++;
            if (lat != x_lat || err8 !== x_err || longint'(mbar8) != x_mb ||
                longint'(xbar8) != x_xb || int'(eidx8) != x_idx) begin
                failures++;
                $display("FAIL random8 M=%0d e=%0d n=%0d: lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d required lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d",
                         m, ee, nn, lat, err8, mbar8, xbar8, eidx8, x_lat, x_err, x_mb, x_xb, x_idx);
            end
            step();
        end
    endtask

    task automatic test_random16();
        int lat, x_lat, x_idx;
        bit x_err;
        longint x_mb, x_xb;
        logic [15:0] m, ee, nn;
        for (int i = 0; i < 30; i++) begin
            nn = 16'($urandom_range(0, 65535));
            if (i % 2 == 0) nn = nn | 16'h8001;
            m  = 16'($urandom_range(0, 65535));
            ee = 16'($urandom_range(0, 65535));
            if ($urandom_range(0, 4) != 0 && nn > 1) m = m % nn;
            if (ee == 0) ee = 16'h0001;
            model(m, ee, nn, 16, x_err, x_mb, x_xb, x_idx, x_lat);
            run16(m, ee, nn, lat);
            checks++;
            if (lat != x_lat || err16 !== x_err || longint'(mbar16) != x_mb ||
                longint'(xbar16) != x_xb || int'(eidx16) != x_idx) begin
                failures++;
                $display("FAIL random16 M=%0d e=%0d n=%0d: lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d required lat=%0d err=%b mbar=%0d xbar=%0d eidx=%0d",
                         m, ee, nn, lat, err16, mbar16, xbar16, eidx16, x_lat, x_err, x_mb, x_xb, x_idx);
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_ignore();
        test_reset_mid_loop();
        test_random8();
        test_random16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mont_pre.md
Name: mont_pre

Overview:
- Pre-processing stage directly upstream of the Montgomery exponentiation block.
- From raw operands M, e, n it produces the Montgomery-domain inputs the exponentiator consumes:
  - M_bar = M·R mod n
  - x_bar = R mod n
  - e_idx = index of the most significant set bit of e
- R = 2^BITLEN.
- Iterative modular doubling, one bit per clock. Pulses done when the outputs are ready to drive the exponentiator's start.

Parameters:
- BITLEN, 1024, operand width in bits; R = 2^BITLEN.
- LOG_BITLEN, 10, width of e_idx and the iteration counter; equals log2(BITLEN).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- M  input  BITLEN  message; required M < n.
- e  input  BITLEN  exponent; required nonzero.
- n  input  BITLEN  modulus; required n > 1.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse, high exactly while state == DONE.
- err  output  1  valid when done is high; 1 means an operand check failed.
- M_bar  output  BITLEN  M·R mod n.
- x_bar  output  BITLEN  R mod n.
- e_idx  output  LOG_BITLEN  highest set bit index of e.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy = done = err = 0.
  - M_bar = x_bar = 0; e_idx = 0; internal latches and counter = 0.
  - Reset mid-operation aborts the computation immediately. No done is issued.
- States: IDLE, LOAD, LOOP, DONE.
- IDLE:
  - On a start edge, latch M, e, n into internal registers.
  - Initialise rm = M, rx = 1, cnt = 0, e_idx = 0, err = 0. Go to LOAD.
  - Without start, hold all outputs.
- LOAD (1 cycle), operand check:
  - If n <= 1, M >= n, or e == 0: set err = 1, M_bar = x_bar = 0, e_idx = 0, go to DONE.
  - Otherwise go to LOOP.
- LOOP (exactly BITLEN cycles, cnt from 0 to BITLEN-1). Each edge:
  - t = {rm,0} (BITLEN+1 bits); rm = (t >= n) ? t - n : t.
  - Same rule applied to rx.
  - If e_latched[cnt] == 1, then e_idx = cnt. The last write wins, so this yields the MSB index.
  - cnt increments.
  - On the edge where cnt == BITLEN-1, copy the final rm/rx into M_bar/x_bar (the doubled values) and go to DONE.
- Width rule: rm and rx are always < n, so 2·r < 2n fits in BITLEN+1 bits. A single conditional subtract keeps r < n. Compare and subtract use the full BITLEN+1 width.
- DONE (1 cycle): done = 1, busy = 1. Next edge goes to IDLE.
- Output holding: M_bar, x_bar, e_idx and err hold their values until the next accepted start.
- Latency, counting the edge that samples start as edge 0:
  - Normal case: done is high after edge BITLEN+1.
  - Error case: done is high after edge 1.
- Start while busy (LOAD/LOOP/DONE) is ignored. Inputs M, e, n may change freely after the sampling edge.
- Start in the same cycle done is high is ignored, because state is DONE, not IDLE. A new start is accepted from the next cycle.
- Downstream: done is intended to drive the exponentiator's start directly. M_bar, x_bar, e_idx are stable when done rises and remain stable afterwards.

Test Plan (BITLEN=8, LOG_BITLEN=3 unless stated):
- Nominal: M=5, n=13, e=8'b00001011, start pulse → done exactly 9 edges after sampling, err=0, x_bar=9, M_bar=6, e_idx=3.
- Edge operands: M=254, n=255, e=8'h80 → x_bar=1, M_bar=254, e_idx=7. Also M=0, n=3, e=1 → M_bar=0, x_bar=1 (256 mod 3), e_idx=0.
- Error checks, each giving done after 1 edge with err=1 and zero outputs:
  - M=13, n=13, e=1.
  - n=1.
  - e=0.
- Busy ignore: start held high for 20 cycles with M=5, n=13, e=11 → exactly one done pulse at edge 9, correct results; a second computation starts only after return to IDLE.
- Reset mid-LOOP: assert rst_n=0 at cnt=4 → all outputs 0 immediately, no done. Restart with new operands and check correct results.
- Full width (BITLEN=1024): random odd n with MSB set, random M<n and e → M_bar, x_bar, e_idx match the reference model, done at edge 1025, and feeding them into the exponentiator reproduces M^e mod n after final conversion.
